// File: rtl/egress_link_shaper.sv
// ---------------------------------------------------------------------------
// egress_link_shaper
//
// Sits behind the CoDel dequeue stage. Drop-marked packets are discarded and
// counted; the remaining packets are buffered in a small FIFO and launched
// onto the physical link at a fixed pace of one packet per TX_CYCLES cycles.
// The block also produces the link-ready signal that CoDel uses
// combinationally to decide dequeue. It keeps saturating statistics for
// transmitted, dropped and overflowed packets.
//
// Ports:
//   clk                : single clock, all logic on posedge
//   reset              : synchronous active-high reset
//   i__packet          : dequeued packet from CoDel (i__packet.valid qualifies)
//   i__drop_packet     : drop mark for i__packet in the same cycle
//   i__link_pause      : link-layer pause, blocks new launches while high
//   o__link_ready      : egress buffer can accept a packet this cycle
//   o__tx_packet       : packet launched on the link ('0 when not valid)
//   o__tx_valid        : one-cycle pulse per launched packet
//   o__tx_count        : packets launched (saturating)
//   o__drop_count      : drop-marked packets discarded (saturating)
//   o__overflow_count  : packets lost to a write while full (saturating)
//   o__occupancy       : current FIFO occupancy
// ---------------------------------------------------------------------------

package CodelPkg;
    typedef struct packed {
        logic        valid;
        logic [7:0]  flow_id;
        logic [31:0] payload;
    } Packet;
endpackage

module egress_link_shaper
    import CodelPkg::*;
#(
    parameter int EGRESS_DEPTH = 4,
    parameter int TX_CYCLES    = 8,
    parameter int STAT_WIDTH   = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  Packet                           i__packet,
    input  logic                            i__drop_packet,
    input  logic                            i__link_pause,
    output logic                            o__link_ready,
    output Packet                           o__tx_packet,
    output logic                            o__tx_valid,
    output logic [STAT_WIDTH-1:0]           o__tx_count,
    output logic [STAT_WIDTH-1:0]           o__drop_count,
    output logic [STAT_WIDTH-1:0]           o__overflow_count,
    output logic [$clog2(EGRESS_DEPTH):0]   o__occupancy
);

    localparam int PTR_W = $clog2(EGRESS_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TX_CYCLES + 1);

    localparam logic [OCC_W-1:0] OCC_FULL_C   = OCC_W'(EGRESS_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ZERO_C   = OCC_W'(0);
    localparam logic [OCC_W-1:0] OCC_ONE_C    = OCC_W'(1);
    localparam logic [TMR_W-1:0] TMR_ZERO_C   = TMR_W'(0);
    localparam logic [TMR_W-1:0] TMR_ONE_C    = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_RELOAD_C = TMR_W'(TX_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_ONE_C    = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + STAT_WIDTH'(1);
        end
    endfunction

    Packet                  mem_r [EGRESS_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [OCC_W-1:0]       occ_r;
    state_t                 state_r;
    logic [TMR_W-1:0]       timer_r;
    logic                   tx_valid_r;
    Packet                  tx_packet_r;
    logic [STAT_WIDTH-1:0]  tx_count_r;
    logic [STAT_WIDTH-1:0]  drop_count_r;
    logic [STAT_WIDTH-1:0]  overflow_count_r;

    logic                   drop_s;
    logic                   push_s;
    logic                   overflow_s;
    logic                   launch_s;
    Packet                  head_s;

    // Classify the incoming packet; fullness uses the registered occupancy
    // only, so a pop in the same cycle never rescues a write while full.
    always_comb begin
        drop_s     = 1'b0;
        push_s     = 1'b0;
        overflow_s = 1'b0;
        if (i__packet.valid) begin
            if (i__drop_packet) begin
                drop_s = 1'b1;
            end else if (occ_r != OCC_FULL_C) begin
                push_s = 1'b1;
            end else begin
                overflow_s = 1'b1;
            end
        end else begin
            drop_s     = 1'b0;
            push_s     = 1'b0;
            overflow_s = 1'b0;
        end
    end

    // Launch decision: slot free, something buffered, link not paused.
    always_comb begin
        launch_s = 1'b0;
        if (((state_r == ST_IDLE) || (timer_r == TMR_ZERO_C)) &&
            (occ_r != OCC_ZERO_C) && !i__link_pause) begin
            launch_s = 1'b1;
        end else begin
            launch_s = 1'b0;
        end
    end

    assign head_s = mem_r[rd_ptr_r];

    // Egress FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
            for (int i = 0; i < EGRESS_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= i__packet;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE_C;
            end
            if (launch_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            case ({push_s, launch_s})
                2'b10:   occ_r <= occ_r + OCC_ONE_C;
                2'b01:   occ_r <= occ_r - OCC_ONE_C;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Pacing FSM: launches the FIFO head and holds off further launches for
    // the remainder of the TX_CYCLES slot. Pause only matters at a launch
    // decision, so a slot already started always runs to completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            timer_r     <= '0;
            tx_valid_r  <= 1'b0;
            tx_packet_r <= '0;
            tx_count_r  <= '0;
        end else begin
            tx_valid_r <= launch_s;
            if (launch_s) begin
                tx_packet_r <= head_s;
                tx_count_r  <= sat_inc(tx_count_r);
                timer_r     <= TMR_RELOAD_C;
                state_r     <= (TX_CYCLES > 1) ? ST_BUSY : ST_IDLE;
            end else begin
                tx_packet_r <= '0;
                case (state_r)
                    ST_BUSY: begin
                        if (timer_r == TMR_ZERO_C) begin
                            state_r <= ST_IDLE;
                        end else begin
                            timer_r <= timer_r - TMR_ONE_C;
                        end
                    end
                    ST_IDLE: begin
                        timer_r <= TMR_ZERO_C;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        timer_r <= TMR_ZERO_C;
                    end
                endcase
            end
        end
    end

    // Drop and overflow statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_r     <= '0;
            overflow_count_r <= '0;
        end else begin
            if (drop_s) begin
                drop_count_r <= sat_inc(drop_count_r);
            end
            if (overflow_s) begin
                overflow_count_r <= sat_inc(overflow_count_r);
            end
        end
    end

    // Ready comes from registered occupancy; reset only forces it low so
    // CoDel never dequeues into a buffer that is being flushed.
    assign o__link_ready      = (occ_r != OCC_FULL_C) && !reset;
    assign o__tx_valid        = tx_valid_r;
    assign o__tx_packet       = tx_packet_r;
    assign o__tx_count        = tx_count_r;
    assign o__drop_count      = drop_count_r;
    assign o__overflow_count  = overflow_count_r;
    assign o__occupancy       = occ_r;

endmodule

// File: tb/tb_egress_link_shaper.sv
module tb_egress_link_shaper;
    import CodelPkg::*;

    localparam int DEPTH = 4;
    localparam int TXC   = 8;
    localparam int SW    = 32;

    logic           clk = 1'b0;
    logic           reset;
    Packet          pkt;
    logic           drop;
    logic           pause;
    logic           link_ready;
    Packet          tx_packet;
    logic           tx_valid;
    logic [SW-1:0]  tx_count;
    logic [SW-1:0]  drop_count;
    logic [SW-1:0]  ovf_count;
    logic [$clog2(DEPTH):0] occ;

    int             n_total = 0;
    int             n_bad   = 0;
    int             cur     = 0;
    int             pulse_cyc[$];
    logic [31:0]    pulse_pay[$];

    egress_link_shaper #(
        .EGRESS_DEPTH (DEPTH),
        .TX_CYCLES    (TXC),
        .STAT_WIDTH   (SW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i__packet         (pkt),
        .i__drop_packet    (drop),
        .i__link_pause     (pause),
        .o__link_ready     (link_ready),
        .o__tx_packet      (tx_packet),
        .o__tx_valid       (tx_valid),
        .o__tx_count       (tx_count),
        .o__drop_count     (drop_count),
        .o__overflow_count (ovf_count),
        .o__occupancy      (occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic Packet mk(input logic [31:0] pay);
        Packet p;
        p.valid   = 1'b1;
        p.flow_id = pay[7:0];
        p.payload = pay;
        return p;
    endfunction

    // Advance one cycle, sample 1 time unit after the edge, log launches.
    task automatic step();
        @(posedge clk);
        #1;
        cur++;
        if (tx_valid) begin
            pulse_cyc.push_back(cur);
            pulse_pay.push_back(tx_packet.payload);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [31:0] pay, input logic dr);
        pkt  = mk(pay);
        drop = dr;
        step();
        pkt  = '0;
        drop = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        pkt   = '0;
        drop  = 1'b0;
        pause = 1'b0;
        reset = 1'b1;
        #1;
        check({tag, "_ready_in_rst"}, link_ready, 0);
        step();
        reset = 1'b0;
        #1;
        check({tag, "_occ"},      occ, 0);
        check({tag, "_txcnt"},    tx_count, 0);
        check({tag, "_dropcnt"},  drop_count, 0);
        check({tag, "_ovfcnt"},   ovf_count, 0);
        check({tag, "_txvalid"},  tx_valid, 0);
        check({tag, "_ready"},    link_ready, 1);
        cur = 0;
        pulse_cyc.delete();
        pulse_pay.delete();
    endtask

    task automatic check_pulse(input string tag, input int idx, input int exp_c,
                               input logic [31:0] exp_p);
        if (idx < pulse_cyc.size()) begin
            check($sformatf("%s_cyc%0d", tag, idx), pulse_cyc[idx], exp_c);
            check($sformatf("%s_pay%0d", tag, idx), pulse_pay[idx], exp_p);
        end else begin
            check($sformatf("%s_missing%0d", tag, idx), 0, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pkt   = '0;
        drop  = 1'b0;
        pause = 1'b0;
        reset = 1'b1;

        // Single packet: write at 0, launch decision at 1, pulse at 2.
        do_reset("t1rst");
        send(32'h0000_00A1, 1'b0);
        check("t1_occ_c1", occ, 1);
        check("t1_txv_c1", tx_valid, 0);
        step();
        check("t1_txv_c2", tx_valid, 1);
        check("t1_pay_c2", tx_packet.payload, 32'h0000_00A1);
        check("t1_occ_c2", occ, 0);
        check("t1_txcnt", tx_count, 1);
        step();
        check("t1_txv_c3", tx_valid, 0);
        check("t1_pkt_zero", tx_packet, 0);
        idle(5);
        check("t1_npulse", pulse_cyc.size(), 1);

        // Burst of four, paced 8 cycles apart in order.
        do_reset("t2rst");
        send(32'hB000_0000, 1'b0);
        send(32'hB000_0001, 1'b0);
        send(32'hB000_0002, 1'b0);
        send(32'hB000_0003, 1'b0);
        check("t2_occ_c4", occ, 3);
        check("t2_ready_c4", link_ready, 1);
        idle(26);
        check("t2_npulse", pulse_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_pulse("t2", i, 2 + 8 * i, 32'hB000_0000 + i);
        end
        check("t2_txcnt", tx_count, 4);

        // Drops interleaved with real packets; valid=0 with drop=1 ignored.
        do_reset("t3rst");
        send(32'hD000_0000, 1'b1);
        send(32'hC000_0001, 1'b0);
        send(32'hD000_0002, 1'b1);
        send(32'hC000_0003, 1'b0);
        send(32'hD000_0004, 1'b1);
        pkt  = '0;
        drop = 1'b1;
        step();
        drop = 1'b0;
        idle(10);
        check("t3_dropcnt", drop_count, 3);
        check("t3_txcnt", tx_count, 2);
        check("t3_npulse", pulse_cyc.size(), 2);
        check_pulse("t3", 0, 3, 32'hC000_0001);
        check_pulse("t3", 1, 11, 32'hC000_0003);

        // Fill while paused, then write while full.
        do_reset("t4rst");
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'hE000_0000 + i, 1'b0);
        end
        check("t4_occ_full", occ, 4);
        check("t4_ready_full", link_ready, 0);
        send(32'hEEEE_EEEE, 1'b0);
        check("t4_ovfcnt", ovf_count, 1);
        check("t4_occ_after_ovf", occ, 4);
        pause = 1'b0;
        step();
        idle(28);
        check("t4_npulse", pulse_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_pulse("t4", i, 6 + 8 * i, 32'hE000_0000 + i);
        end
        check("t4_ovfcnt_end", ovf_count, 1);

        // Pause for 20 cycles, release, then a pause inside the slot.
        do_reset("t5rst");
        pause = 1'b1;
        send(32'hF000_0000, 1'b0);
        send(32'hF000_0001, 1'b0);
        idle(18);
        check("t5_none_paused", pulse_cyc.size(), 0);
        pause = 1'b0;
        step();
        step();
        pause = 1'b1;
        idle(3);
        pause = 1'b0;
        idle(7);
        check("t5_npulse", pulse_cyc.size(), 2);
        check_pulse("t5", 0, 21, 32'hF000_0000);
        check_pulse("t5", 1, 29, 32'hF000_0001);

        // Reset in the middle of a slot with three packets buffered.
        do_reset("t6rst");
        for (int i = 0; i < 4; i++) begin
            send(32'hA600_0000 + i, 1'b0);
        end
        step();
        check("t6_occ_pre", occ, 3);
        check("t6_txcnt_pre", tx_count, 1);
        reset = 1'b1;
        #1;
        check("t6_ready_in_rst", link_ready, 0);
        step();
        reset = 1'b0;
        #1;
        check("t6_occ_post", occ, 0);
        check("t6_txcnt_post", tx_count, 0);
        check("t6_ready_post", link_ready, 1);
        check("t6_txv_post", tx_valid, 0);
        pulse_cyc.delete();
        pulse_pay.delete();
        idle(20);
        check("t6_no_pulse", pulse_cyc.size(), 0);
        check("t6_txcnt_end", tx_count, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
